// File: rtl/serial_subtractor_8bit.sv
// Bit-serial two's-complement subtractor (diff = a - b), one bit per clock, LSB first.
// Optional macro SUB_OVERFLOW_EN adds a signed-overflow output captured with the result.
module serial_subtractor_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
`ifdef SUB_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d, diff_q, diff_d;
    logic             br_q, br_d, bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             x, y, dbit, last;

    assign x    = sa_q[0];
    assign y    = sb_q[0];
    assign dbit = x ^ y ^ br_q;
    assign last = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                res_d = {dbit, res_q[WIDTH-1:1]};
                br_d  = (~x & y) | (~(x ^ y) & br_q);
                cnt_d = cnt_q + CW'(1);
                // Output registers only load on completion, so partial results never show.
                if (last) begin
                    diff_d  = res_d;
                    bout_d  = br_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SUB_OVERFLOW_EN
    logic am_q, am_d, bm_q, bm_d, ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            am_q  <= 1'b0;
            bm_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            am_q  <= am_d;
            bm_q  <= bm_d;
            ovf_q <= ovf_d;
        end
    end

    // The final serial bit is the result MSB.
    always_comb begin
        am_d  = am_q;
        bm_d  = bm_q;
        ovf_d = ovf_q;
        if (state_q == IDLE && in_valid) begin
            am_d = a[WIDTH-1];
            bm_d = b[WIDTH-1];
        end else if (state_q == RUN && last) begin
            ovf_d = (am_q != bm_q) && (dbit != am_q);
        end
    end

    assign overflow = ovf_q;
`endif

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;
endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Directed-vector bench for serial_subtractor_8bit; overflow checked when SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor_8bit;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, borrow_out, busy;
    logic [W-1:0] a, b, diff;
`ifdef SUB_OVERFLOW_EN
    logic         overflow;
`endif
    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    serial_subtractor_8bit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow_out(borrow_out),
`ifdef SUB_OVERFLOW_EN
        .overflow(overflow),
`endif
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int hold,
                          input bit inject, input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin tick; n++; end
        chk("in_ready_pre", in_ready, 1);
        a = av; b = bv; in_valid = 1'b1; out_ready = (hold == 0);
        tick;
        in_valid = 1'b0; a = ~av; b = 8'h3C;
        chk("busy_run", busy, 1);
        chk("in_ready_run", in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            if (inject && n == 1) begin in_valid = 1'b1; a = 8'h55; end
            if (inject && n == 3) in_valid = 1'b0;
            tick;
            n++;
        end
        in_valid = 1'b0;
        chk("latency", n, 8);
        chk("diff", diff, ed);
        chk("borrow", borrow_out, eb);
`ifdef SUB_OVERFLOW_EN
        chk("overflow", overflow, eo);
`endif
        for (int i = 0; i < hold; i++) begin
            tick;
            chk("hold_valid", out_valid, 1);
            chk("hold_diff", diff, ed);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick;
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_busy", busy, 0);
        chk("post_diff_kept", diff, ed);
        out_ready = 1'b0;
        if (eo === 1'bx) $display("unexpected X in expectation");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        tick; tick;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
`ifdef SUB_OVERFLOW_EN
        chk("rst_overflow", overflow, 0);
`endif
        rst = 1'b0;
        tick;

        run_op(8'd10, 8'd3,  0, 1'b0, 8'd7,   1'b0, 1'b0);
        run_op(8'd3,  8'd10, 0, 1'b0, 8'hF9,  1'b1, 1'b0);
        run_op(8'h80, 8'h01, 0, 1'b0, 8'h7F,  1'b0, 1'b1);
        run_op(8'h00, 8'h00, 5, 1'b0, 8'h00,  1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 0, 1'b1, 8'hFE,  1'b0, 1'b0);
        run_op(8'h00, 8'h01, 2, 1'b0, 8'hFF,  1'b1, 1'b0);
        run_op(8'h7F, 8'hFF, 0, 1'b0, 8'h80,  1'b1, 1'b1);
        run_op(8'hA5, 8'hA5, 0, 1'b0, 8'h00,  1'b0, 1'b0);

        // Abort 4 cycles into RUN.
        a = 8'hC3; b = 8'h11; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick; tick; tick; tick;
        chk("abort_busy_pre", busy, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow_out, 0);
        run_op(8'd1, 8'd2, 0, 1'b0, 8'hFF, 1'b1, 1'b0);

        // rst and in_valid together: operands must not be captured.
        rst = 1'b1; in_valid = 1'b1; a = 8'h05; b = 8'h01;
        tick;
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_wins_busy", busy, 0);
        chk("rst_wins_in_ready", in_ready, 1);
        tick;
        chk("rst_wins_busy2", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
